// File: rtl/mmio_responder.sv
// MMIO responder: a 16-byte window with GPIO, a free-running COUNT, a compare register and a sticky match STATUS,
// served through a busywait load/store handshake with a configurable wait latency.
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  read,
    input  logic [2:0]  write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic [31:0] gpio_out,
    output logic        irq
);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]    rtype_q, rtype_d;
    logic [1:0]    wsize_q, wsize_d;
    logic          is_rd_q, is_rd_d, is_wr_q, is_wr_d;
    logic          busy_c, access_c;
    logic [31:0]   readdata_q, readdata_d, gpio_q, gpio_d;
    logic [31:0]   count_q, count_d, cmp_q, cmp_d;
    logic          status_q, status_d;

    // Handshake FSM: capture in IDLE, count down in WAIT, present result in DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rtype_d  = rtype_q;
        wsize_d  = wsize_q;
        is_rd_d  = is_rd_q;
        is_wr_d  = is_wr_q;
        busy_c   = 1'b0;
        access_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (read[3] || write[2]) begin
                    busy_c  = 1'b1;
                    addr_d  = address;
                    wdata_d = writedata;
                    rtype_d = read[2:0];
                    wsize_d = write[1:0];
                    is_wr_d = write[2];
                    is_rd_d = read[3] & ~write[2];
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                busy_c = 1'b1;
                if (cnt_q == '0) begin
                    access_c = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic        hit_c, do_wr_c, clr_c;
    logic [1:0]  sel_c;
    logic [3:0]  wmask_c;
    logic [7:0]  ld_byte_c;
    logic [15:0] ld_half_c;
    logic [31:0] rword_c, ld_c, wval_c, bmask_c;

    // Register file access: lane selection, extension, masked store merge
    always_comb begin
        hit_c = (addr_q[31:4] == BASE_ADDR[31:4]);
        sel_c = addr_q[3:2];
        case (sel_c)
            2'd0:    rword_c = gpio_q;
            2'd1:    rword_c = count_q;
            2'd2:    rword_c = cmp_q;
            default: rword_c = {31'b0, status_q};
        endcase
        ld_byte_c = 8'(rword_c >> {addr_q[1:0], 3'b000});
        ld_half_c = 16'(rword_c >> {addr_q[1], 4'b0000});
        case (rtype_q)
            3'b000:  ld_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            3'b001:  ld_c = {{16{ld_half_c[15]}}, ld_half_c};
            3'b010:  ld_c = rword_c;
            3'b100:  ld_c = {24'b0, ld_byte_c};
            3'b101:  ld_c = {16'b0, ld_half_c};
            default: ld_c = '0;
        endcase

        wmask_c = '0;
        wval_c  = wdata_q;
        case (wsize_q)
            2'b00: begin
                wmask_c = 4'b0001 << addr_q[1:0];
                wval_c  = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wmask_c = addr_q[1] ? 4'b1100 : 4'b0011;
                wval_c  = {2{wdata_q[15:0]}};
            end
            2'b10:   wmask_c = 4'b1111;
            default: wmask_c = '0;
        endcase
        bmask_c = '0;
        for (int i = 0; i < 4; i++) begin
            bmask_c[i*8 +: 8] = {8{wmask_c[i]}};
        end

        do_wr_c = access_c & is_wr_q & hit_c;
        clr_c   = do_wr_c && (sel_c == 2'd3) && bmask_c[0] && wval_c[0];

        readdata_d = readdata_q;
        if (access_c) begin
            readdata_d = (hit_c && is_rd_q) ? ld_c : '0;
        end
        gpio_d   = (do_wr_c && sel_c == 2'd0) ? ((gpio_q & ~bmask_c) | (wval_c & bmask_c)) : gpio_q;
        cmp_d    = (do_wr_c && sel_c == 2'd2) ? ((cmp_q & ~bmask_c) | (wval_c & bmask_c)) : cmp_q;
        count_d  = count_q + 32'd1;
        // a match on the same edge as a clear keeps the flag set
        status_d = (count_q == cmp_q) | (status_q & ~clr_c);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rtype_q    <= '0;
            wsize_q    <= '0;
            is_rd_q    <= 1'b0;
            is_wr_q    <= 1'b0;
            readdata_q <= '0;
            gpio_q     <= '0;
            count_q    <= '0;
            cmp_q      <= 32'hFFFF_FFFF;
            status_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rtype_q    <= rtype_d;
            wsize_q    <= wsize_d;
            is_rd_q    <= is_rd_d;
            is_wr_q    <= is_wr_d;
            readdata_q <= readdata_d;
            gpio_q     <= gpio_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            status_q   <= status_d;
        end
    end

    assign busywait = busy_c & ~reset;
    assign readdata = readdata_q;
    assign gpio_out = gpio_q;
    assign irq      = status_q;

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, meaning a 16-byte register window is decoded when address[31:4] == BASE_ADDR[31:4].
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request capture and completion, legal range 1..15.
REQ-003 SHALL have port `clock`, input, width 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port `reset`, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL have port `read`, input, width 4: read[3] is the load request; read[2:0] is the load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-006 SHALL have port `write`, input, width 3: write[2] is the store request; write[1:0] is the store size (00 byte, 01 half, 10 word).
REQ-007 SHALL have port `address`, input, width 32: byte address.
REQ-008 SHALL have port `writedata`, input, width 32: store data, right-aligned.
REQ-009 SHALL have port `readdata`, output, width 32: load result, right-aligned and extended.
REQ-010 SHALL have port `busywait`, output, width 1: high while a request is in progress.
REQ-011 SHALL have port `gpio_out`, output, width 32: drives the GPIO register.
REQ-012 SHALL have port `irq`, output, width 1: equals STATUS[0].

Function
REQ-013 SHALL implement four word registers at these offsets: 0x0 GPIO (RW); 0x4 COUNT (RO, free-running, +1 every cycle, wraps 0xFFFF_FFFF->0); 0x8 CMP (RW); 0xC STATUS (bit0 sticky match, write-1-to-clear, bits 31:1 read 0).
REQ-014 SHALL set STATUS[0] in the cycle after COUNT == CMP; a simultaneous set and W1C SHALL leave the bit at 1.
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-016 In IDLE, with read[3] or write[2] high, SHALL drive busywait high combinationally in the same cycle, capture address, type and data, load wait counter = LATENCY-1, and go to WAIT.
REQ-017 In WAIT, SHALL hold busywait high and decrement the counter; at 0 SHALL perform the access and go to DONE.
REQ-018 In DONE, SHALL hold busywait low and readdata valid for exactly one cycle, ignore requests, then go to IDLE.
REQ-019 Total busywait-high time SHALL be LATENCY+1 cycles per request.
REQ-020 With read[3] and write[2] both high, SHALL execute the store only and return readdata 0.
REQ-021 SHALL select byte/half lanes by captured address[1:0].
REQ-022 SHALL sign-extend LB/LH and zero-extend LBU/LHU.
REQ-023 SHALL perform misaligned half or word accesses using address[1:0] forced to 0 for half (bit0) and word (bits 1:0).
REQ-024 Stores SHALL update only the addressed lanes; a store to COUNT SHALL be ignored.
REQ-025 Out-of-window requests SHALL complete with the same handshake, readdata 0, and no state change.
REQ-026 readdata SHALL hold its last value outside DONE.

Reset
REQ-027 reset high SHALL asynchronously force state IDLE, busywait 0, readdata 0, GPIO 0, COUNT 0, CMP 32'hFFFF_FFFF, STATUS 0, and irq 0.
REQ-028 reset asserted mid-request SHALL abort the request with no register write.
REQ-029 After reset release, COUNT SHALL restart from 0 on the first edge.

Verification
REQ-030 Scenario: after reset, LW at 0x1000 -> busywait high for 3 cycles (LATENCY=2), then readdata 0x0000_0000 for one cycle.
REQ-031 Scenario: SW 0xDEAD_BEEF to 0x1000, then SB 0x12 to 0x1002 -> gpio_out = 0xDE12_BEEF; LB at 0x1003 -> 0xFFFF_FFDE; LBU -> 0x0000_00DE.
REQ-032 Scenario: SW 20 to 0x1008 -> irq rises the cycle after COUNT = 20; SW 1 to 0x100C clears irq; irq stays low until the next match.
REQ-033 Scenario: LW at 0x2000 -> full handshake, readdata 0, no register change; SW to 0x1004 -> COUNT unaffected.
REQ-034 Scenario: reset pulse during WAIT of SW to 0x1000 -> gpio_out 0, busywait 0 immediately, next request handled normally.
REQ-035 Scenario: request held high through DONE -> exactly one access performed; a new capture occurs only on the IDLE cycle.
